// File: rtl/uart_rx_byte.sv
// UART 8N1 receiver with a 1-deep valid/ready output buffer.
// Define UART_RX_PARITY_EN for 8E1 framing with a sticky o_parity_err output.
module uart_rx_byte #(
  parameter int BIT_DIV     = 469,
  parameter int SYNC_STAGES = 2
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_rxd,
  output logic [7:0] o_data,
  output logic       o_valid,
  input  logic       i_ready,
  output logic       o_frame_err,
  output logic       o_overrun,
`ifdef UART_RX_PARITY_EN
  output logic       o_parity_err,
`endif
  input  logic       i_clear_err
);

  localparam int CNT_W = $clog2(BIT_DIV);
  localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(BIT_DIV / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(BIT_DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_RX_PARITY_EN
    S_PARITY,
`endif
    S_STOP,
    S_BREAK
  } state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES:0]   prime_q;
  logic                   rxs;
  logic                   rxs_d;
  logic                   rx_fall;
  logic [CNT_W-1:0]       cnt;
  logic [2:0]             bit_idx;
  logic                   bit_tick;
  logic [7:0]             shift_p0;
  logic                   done_p1;

`ifdef UART_RX_PARITY_EN
  function automatic logic parity_bad(input logic [7:0] d, input logic p);
    return ^{d, p};
  endfunction
`endif

  assign rxs      = sync_q[SYNC_STAGES-1];
  assign bit_tick = (cnt == FULL_M1);
  // prime_q keeps the reset-time ones in the synchroniser from looking like a
  // falling edge, so a line held low across reset is ignored until it rises.
  assign rx_fall  = prime_q[SYNC_STAGES] & rxs_d & ~rxs;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      sync_q  <= '1;
      prime_q <= '0;
      rxs_d   <= 1'b1;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], i_rxd};
      prime_q <= {prime_q[SYNC_STAGES-1:0], 1'b1};
      rxs_d   <= rxs;
    end
  end

  // Stage p0: frame FSM, bit sampling and error detection
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state       <= S_IDLE;
      cnt         <= '0;
      bit_idx     <= '0;
      done_p1     <= 1'b0;
      o_frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      o_parity_err <= 1'b0;
`endif
    end else begin
      done_p1     <= 1'b0;
      o_frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      if (i_clear_err) o_parity_err <= 1'b0;
`endif
      case (state)
        S_IDLE: begin
          if (rx_fall) begin
            state <= S_START;
            cnt   <= '0;
          end
        end
        S_START: begin
          if (cnt == HALF_M1) begin
            cnt     <= '0;
            bit_idx <= '0;
            state   <= rxs ? S_IDLE : S_DATA;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_DATA: begin
          if (bit_tick) begin
            cnt     <= '0;
            bit_idx <= bit_idx + 1'b1;
            if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              state <= S_PARITY;
`else
              state <= S_STOP;
`endif
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
`ifdef UART_RX_PARITY_EN
        S_PARITY: begin
          if (bit_tick) begin
            cnt   <= '0;
            state <= S_STOP;
            if (parity_bad(shift_p0, rxs)) o_parity_err <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
`endif
        S_STOP: begin
          if (bit_tick) begin
            cnt <= '0;
            if (rxs) begin
              done_p1 <= 1'b1;
              state   <= S_IDLE;
            end else begin
              o_frame_err <= 1'b1;
              state       <= S_BREAK;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_BREAK: begin
          if (rxs) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (state == S_DATA && bit_tick) shift_p0 <= {rxs, shift_p0[7:1]};
  end

  // Stage p1: output buffer and overrun tracking
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      o_data    <= '0;
      o_valid   <= 1'b0;
      o_overrun <= 1'b0;
    end else begin
      if (i_clear_err) o_overrun <= 1'b0;
      if (done_p1) begin
        if (!o_valid || i_ready) begin
          o_data  <= shift_p0;
          o_valid <= 1'b1;
        end else begin
          o_overrun <= 1'b1;
        end
      end else if (o_valid && i_ready) begin
        o_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_byte.sv
// Scoreboard bench for uart_rx_byte: directed frames plus randomized traffic.
module tb_uart_rx_byte;
  localparam int BD = 8;
  localparam int SS = 2;
`ifdef UART_RX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  localparam int LAT = SS + BD / 2 + (NB - 1) * BD + 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       rxd;
  logic       clr;
  logic       ready_force;
  logic       ready_val;
  logic       ready_rnd = 1'b0;
  logic       i_ready;
  logic [7:0] o_data;
  logic       o_valid;
  logic       o_frame_err;
  logic       o_overrun;
`ifdef UART_RX_PARITY_EN
  logic       o_parity_err;
`endif

  int         tests = 0;
  int         fails = 0;
  int         fe_count = 0;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;
  assign i_ready = ready_force ? ready_val : ready_rnd;

  uart_rx_byte #(.BIT_DIV(BD), .SYNC_STAGES(SS)) dut (
    .i_clk(clk),
    .i_reset(rst),
    .i_rxd(rxd),
    .o_data(o_data),
    .o_valid(o_valid),
    .i_ready(i_ready),
    .o_frame_err(o_frame_err),
    .o_overrun(o_overrun),
`ifdef UART_RX_PARITY_EN
    .o_parity_err(o_parity_err),
`endif
    .i_clear_err(clr)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [10:0] frame_bits(input logic [7:0] b, input logic stop,
                                             input logic flip);
    logic [10:0] f;
    f      = '1;
    f[0]   = 1'b0;
    f[8:1] = b;
`ifdef UART_RX_PARITY_EN
    f[9]   = (^b) ^ flip;
    f[10]  = stop;
`else
    f[9]   = stop;
`endif
    return f;
  endfunction

  task automatic send_bits(input logic [10:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      rxd = bits[i];
      tick(BD);
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop, input logic flip);
    send_bits(frame_bits(b, stop, flip), NB);
  endtask

  always @(posedge clk) begin
    #1;
    ready_rnd = 1'($urandom_range(0, 1));
  end

  // Monitor: every handshake consumes the oldest expected byte
  always @(negedge clk) begin
    if (!rst) begin
      if (o_frame_err) fe_count++;
      if (o_valid && i_ready) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_byte: got %02h, none expected", o_data);
        end else begin
          check("rx_byte", {24'd0, o_data}, {24'd0, exp_q.pop_front()});
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int fe0;
    int w;
    int fe_rand;
    logic pexp;
    logic [7:0] b;
    logic bad;
    logic flip;

    rst = 1'b1; rxd = 1'b1; clr = 1'b0; ready_force = 1'b1; ready_val = 1'b1;
    tick(3);
    check("reset_valid", o_valid, 0);
    check("reset_data", o_data, 0);
    check("reset_frame_err", o_frame_err, 0);
    check("reset_overrun", o_overrun, 0);
`ifdef UART_RX_PARITY_EN
    check("reset_parity_err", o_parity_err, 0);
`endif
    rst = 1'b0;
    tick(5);

    // Single byte, consumer always ready, with latency measurement
    exp_q.push_back(8'hA5);
    lat = 0;
    fork
      send_frame(8'hA5, 1'b1, 1'b0);
      begin
        do begin
          tick(1);
          lat++;
        end while (!o_valid && lat < 300);
      end
    join
    tests++;
    if (lat < LAT - 1 || lat > LAT + 1) begin
      fails++;
      $display("FAIL latency: got %0d cycles, expected %0d +/-1", lat, LAT);
    end
    rxd = 1'b1;
    tick(1);
    check("valid_one_cycle", o_valid, 0);
    check("a5_frame_err_count", fe_count, 0);
    check("a5_overrun", o_overrun, 0);

    // Overrun with stalled consumer
    ready_val = 1'b0;
    tick(2);
    exp_q.push_back(8'h3C);
    send_frame(8'h3C, 1'b1, 1'b0);
    rxd = 1'b1;
    tick(2);
    send_frame(8'h81, 1'b1, 1'b0);
    rxd = 1'b1;
    tick(4);
    check("ovr_valid", o_valid, 1);
    check("ovr_data_held", o_data, 8'h3C);
    check("ovr_set", o_overrun, 1);
    clr = 1'b1;
    tick(1);
    clr = 1'b0;
    check("ovr_cleared", o_overrun, 0);
    ready_val = 1'b1;
    tick(1);
    check("ovr_handshake_valid", o_valid, 0);
    check("ovr_queue_empty", exp_q.size(), 0);

    // Bad stop bit followed by a held-low line
    fe0 = fe_count;
    send_frame(8'h55, 1'b0, 1'b0);
    rxd = 1'b0;
    tick(40);
    rxd = 1'b1;
    tick(10);
    check("break_one_pulse", fe_count - fe0, 1);
    check("break_no_valid", o_valid, 0);
    exp_q.push_back(8'h12);
    send_frame(8'h12, 1'b1, 1'b0);
    rxd = 1'b1;
    tick(6);
    check("after_break_queue_empty", exp_q.size(), 0);

    // Short glitch on idle line
    rxd = 1'b0;
    tick(2);
    rxd = 1'b1;
    tick(20);
    check("glitch_no_valid", o_valid, 0);
    exp_q.push_back(8'hFF);
    send_frame(8'hFF, 1'b1, 1'b0);
    rxd = 1'b1;
    tick(6);
    check("after_glitch_queue_empty", exp_q.size(), 0);

    // Reset during the data bits of 0x99, line left low across release
    fe0 = fe_count;
    send_bits(frame_bits(8'h99, 1'b1, 1'b0), 4);
    rst = 1'b1;
    tick(2);
    check("midreset_valid", o_valid, 0);
    check("midreset_data", o_data, 0);
    check("midreset_frame_err", o_frame_err, 0);
    check("midreset_overrun", o_overrun, 0);
    tick(1);
    rst = 1'b0;
    tick(20);
    check("low_after_reset_no_valid", o_valid, 0);
    rxd = 1'b1;
    tick(10);
    exp_q.push_back(8'h42);
    send_frame(8'h42, 1'b1, 1'b0);
    rxd = 1'b1;
    tick(6);
    check("midreset_frame_err_count", fe_count - fe0, 0);
    check("after_reset_queue_empty", exp_q.size(), 0);

`ifdef UART_RX_PARITY_EN
    exp_q.push_back(8'h07);
    send_frame(8'h07, 1'b1, 1'b0);
    rxd = 1'b1;
    tick(4);
    check("parity_good", o_parity_err, 0);
    exp_q.push_back(8'h07);
    send_frame(8'h07, 1'b1, 1'b1);
    rxd = 1'b1;
    tick(4);
    check("parity_bad", o_parity_err, 1);
    check("parity_byte_delivered", exp_q.size(), 0);
    clr = 1'b1;
    tick(1);
    clr = 1'b0;
    check("parity_cleared", o_parity_err, 0);
`endif

    // Randomized traffic with a randomly stalling consumer
    ready_force = 1'b0;
    fe0 = fe_count;
    fe_rand = 0;
    pexp = 1'b0;
    for (int n = 0; n < 24; n++) begin
      b = 8'($urandom);
      bad = ($urandom_range(0, 4) == 0);
`ifdef UART_RX_PARITY_EN
      flip = ($urandom_range(0, 3) == 0);
`else
      flip = 1'b0;
`endif
      if (bad) fe_rand++;
      else exp_q.push_back(b);
      if (flip) pexp = 1'b1;
      send_frame(b, !bad, flip);
      rxd = 1'b1;
      tick($urandom_range(2, 12));
    end
    w = 0;
    while (exp_q.size() != 0 && w < 500) begin
      tick(1);
      w++;
    end
    check("random_drain", exp_q.size(), 0);
    check("random_frame_errs", fe_count - fe0, fe_rand);
    check("random_no_overrun", o_overrun, 0);
`ifdef UART_RX_PARITY_EN
    check("random_parity_err", o_parity_err, pexp);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/uart_rx_byte.md
Name: uart_rx_byte

Overview:
- UART receiver: the receive counterpart of the optional UART transmit path, enabled when the board UART module is on.
- Deserialises an asynchronous 8N1 serial line into bytes.
- Presents each byte on a 1-deep valid/ready output buffer to the cartridge-side controller.
- Runs in the local fabric clock domain; bit timing comes from a fixed clocks-per-bit divisor taken from the board configuration.

Parameters:
- BIT_DIV, 469, fabric clock cycles per serial bit (≥ 4); 54 MHz / 115200 baud.
- SYNC_STAGES, 2, input synchroniser depth on i_rxd (≥ 2).

Ports:
- i_clk  in  1  fabric clock
- i_reset  in  1  reset, asynchronous, active-high
- i_rxd  in  1  serial input, idle high, asynchronous to i_clk
- o_data  out  8  received byte, LSB received first
- o_valid  out  1  o_data holds an unconsumed byte
- i_ready  in  1  consumer accepts o_data when o_valid && i_ready
- o_frame_err  out  1  one-cycle pulse: stop bit sampled low
- o_overrun  out  1  sticky: a completed byte was dropped because the buffer was full
- i_clear_err  in  1  clears o_overrun (and parity error when present)

Behaviour:
- Reset values (async, active-high, any state): state=IDLE, o_data=0, o_valid=0, o_frame_err=0, o_overrun=0, synchroniser flops=1, bit counter=0, clock counter=0.
- Synchroniser: i_rxd passes through SYNC_STAGES flops; all logic uses the synchronised value rxs.
- IDLE:
  - Falling edge of rxs → START, clock counter cleared.
- START:
  - Count BIT_DIV/2 (integer division) cycles, then sample rxs.
  - rxs=1: false start, go to IDLE, no output.
  - rxs=0: go to DATA, bit index=0, counter reloaded.
- DATA:
  - Sample every BIT_DIV cycles into shift register, LSB first.
  - After bit index 7 is sampled → STOP (or PARITY when the optional feature is enabled).
- STOP:
  - Sample after BIT_DIV cycles.
  - rxs=1: byte complete, go to IDLE.
  - rxs=0: o_frame_err pulses high for exactly 1 cycle, byte discarded, go to BREAK.
- BREAK:
  - Wait until rxs=1, then go to IDLE.
  - A held-low line produces only one frame_err pulse.
- Output buffer, on byte complete:
  - Buffer empty: o_data loaded and o_valid=1 on the next cycle.
  - Buffer full, no handshake this cycle: new byte dropped, o_data unchanged, o_overrun set.
  - Buffer full, handshake in the same cycle: new byte loaded, o_valid stays 1, no overrun.
- Handshake: o_valid && i_ready with no completion that cycle → o_valid=0 next cycle; o_data holds its last value.
- Latency: from the falling edge at i_rxd to o_valid=1 is SYNC_STAGES + 1 + BIT_DIV/2 + 9·BIT_DIV + 1 cycles, ±1 for input phase.
- Error clear: i_clear_err clears o_overrun next cycle. If an overrun occurs in the same cycle, set wins.
- Reset mid-frame: frame aborted immediately. After release, reception resumes only on a new falling edge; a line already low is ignored until it returns high.
- No byte is ever emitted with o_frame_err asserted.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- When defined:
  - Frame is 8E1; PARITY state follows DATA and samples one bit after BIT_DIV cycles.
  - Extra output o_parity_err (1 bit, sticky, reset 0, cleared by i_clear_err) is set when the XOR of 8 data bits and the parity bit is 1.
  - The byte is still delivered.
- When undefined: no PARITY state, no o_parity_err port, frame is 8N1.

Test Plan:
- BIT_DIV=8: send 0xA5 8N1, i_ready=1 → o_valid one cycle with o_data=0xA5, o_frame_err=0, o_overrun=0.
- i_ready=0: send 0x3C then 0x81 → o_data stays 0x3C, o_valid=1, o_overrun=1 after the second stop. i_clear_err → o_overrun=0. Handshake → o_valid=0.
- Send 0x55 with stop bit forced low, then hold the line low 40 cycles → exactly one o_frame_err pulse, o_valid stays 0. Line high, then send 0x12 → o_data=0x12.
- Low glitch of 2 cycles on idle line → no o_valid, FSM back in IDLE, following 0xFF received correctly.
- Assert i_reset in the middle of the DATA bits of 0x99, release, send 0x42 → only 0x42 delivered, all outputs 0 during reset.
- UART_RX_PARITY_EN defined: send 0x07 with parity 1 (correct even) → o_parity_err=0. Send 0x07 with parity 0 → o_parity_err=1, o_data=0x07 delivered.
